// File: rtl/alu_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_pipe_pkg                                                     |
// | Purpose : Shared command codes, NZCV bit positions and control states for  |
// |           the registered pipeline ALU.                                     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package alu_pipe_pkg;

  // 4-bit command encoding
  localparam logic [3:0] CMD_MOV = 4'b0001;
  localparam logic [3:0] CMD_ADD = 4'b0010;
  localparam logic [3:0] CMD_ADC = 4'b0011;
  localparam logic [3:0] CMD_SUB = 4'b0100;
  localparam logic [3:0] CMD_SBC = 4'b0101;
  localparam logic [3:0] CMD_AND = 4'b0110;
  localparam logic [3:0] CMD_ORR = 4'b0111;
  localparam logic [3:0] CMD_EOR = 4'b1000;
  localparam logic [3:0] CMD_MVN = 4'b1001;
  localparam logic [3:0] CMD_MUL = 4'b1010;

  // Bit positions inside a {N,Z,C,V} nibble
  localparam int NZCV_N = 3;
  localparam int NZCV_Z = 2;
  localparam int NZCV_C = 1;
  localparam int NZCV_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage : alu_pipe_pkg
`default_nettype wire

// File: rtl/alu_pipe_mul.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_mul_iter                                                     |
// | Purpose : Iterative shift-add multiplier, one partial product per clock,   |
// |           WIDTH steps per operation. Keeps the low WIDTH product bits.     |
// |           Present only when ALU_PIPE_MUL_EN is defined.                    |
// | Ports   : clk, rst_n (async, active-low), start (load operands a/b),       |
// |           done (high during the cycle whose edge performs the last step),  |
// |           product (value after the current step while running, final      |
// |           product once idle).                                              |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
`ifdef ALU_PIPE_MUL_EN
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int               CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  logic             r_active;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_step;

  assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign done       = r_active && (r_cnt == LAST_STEP);
  // Exposing the post-step value lets the parent write the product on the
  // same edge as the final step instead of one cycle later.
  assign product    = r_active ? w_acc_step : r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (start) begin
      r_active <= 1'b1;
      r_cnt    <= '0;
      r_mcand  <= a;
      r_mplier <= b;
      r_acc    <= '0;
    end else if (r_active) begin
      r_acc    <= w_acc_step;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (done) r_active <= 1'b0;
    end
  end

endmodule : alu_mul_iter
`endif
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : alu_pipe                                                         |
// | Purpose : Registered ALU with valid/ready handshakes, an output register,  |
// |           an NZCV status register feeding ADC/SBC carry-in and an optional |
// |           iterative multiply (compile macro ALU_PIPE_MUL_EN).              |
// | Ports   : clk, rst_n (async, active-low)                                   |
// |           in_valid/in_ready, command[3:0], s_flag, op_a, op_b  (request)   |
// |           out_valid/out_ready, result, res_nzcv[3:0]           (response)  |
// |           status_nzcv[3:0] architectural flags, busy = multiply running    |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       command,
  input  logic             s_flag,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       res_nzcv,
  output logic [3:0]       status_nzcv,
  output logic             busy
);
  import alu_pipe_pkg::*;

  localparam int MSB = WIDTH - 1;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic [3:0]       r_res_nzcv;
  logic [3:0]       r_status;

  logic             w_free;
  logic             w_accept;
  logic             w_load_alu;
  logic             w_defined;
  logic             w_add;
  logic             w_sub;
  logic             w_c;
  logic             w_v;
  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic [3:0]       w_nzcv;

`ifdef ALU_PIPE_MUL_EN
  state_t           r_state;
  logic             r_mul_s;
  logic             w_is_mul;
  logic             w_mul_done;
  logic             w_load_mul;
  logic [WIDTH-1:0] w_product;
  logic [3:0]       w_mul_nzcv;
`endif

  assign w_free   = !r_out_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_cin    = r_status[NZCV_C];

  // Single-cycle datapath; arithmetic is done at WIDTH+1 bits so the top bit
  // is the carry (or the borrow for subtraction).
  always_comb begin
    w_sum     = '0;
    w_res     = '0;
    w_c       = 1'b0;
    w_v       = 1'b0;
    w_add     = 1'b0;
    w_sub     = 1'b0;
    w_defined = 1'b1;
`ifdef ALU_PIPE_MUL_EN
    w_is_mul  = 1'b0;
`endif
    case (command)
      CMD_MOV: w_res = op_b;
      CMD_MVN: w_res = ~op_b;
      CMD_ADD: begin
        w_sum = {1'b0, op_a} + {1'b0, op_b};
        w_add = 1'b1;
      end
      CMD_ADC: begin
        w_sum = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, w_cin};
        w_add = 1'b1;
      end
      CMD_SUB: begin
        w_sum = {1'b0, op_a} - {1'b0, op_b};
        w_sub = 1'b1;
      end
      CMD_SBC: begin
        // a - b - 1 + C is the same as a - b - !C modulo 2^(WIDTH+1)
        w_sum = {1'b0, op_a} - {1'b0, op_b} - {{WIDTH{1'b0}}, !w_cin};
        w_sub = 1'b1;
      end
      CMD_AND: w_res = op_a & op_b;
      CMD_ORR: w_res = op_a | op_b;
      CMD_EOR: w_res = op_a ^ op_b;
`ifdef ALU_PIPE_MUL_EN
      CMD_MUL: w_is_mul = 1'b1;
`endif
      default: w_defined = 1'b0;
    endcase
    if (w_add || w_sub) begin
      w_res = w_sum[WIDTH-1:0];
      w_c   = w_sum[WIDTH];
    end
    if (w_add) w_v = (op_a[MSB] == op_b[MSB]) && (w_res[MSB] != op_a[MSB]);
    if (w_sub) w_v = (op_a[MSB] != op_b[MSB]) && (w_res[MSB] != op_a[MSB]);
  end

  assign w_nzcv = {w_res[MSB], (w_res == '0), w_c, w_v};

`ifdef ALU_PIPE_MUL_EN
  assign in_ready   = (r_state == IDLE) && w_free;
  assign busy       = (r_state != IDLE);
  assign w_load_alu = w_accept && !w_is_mul;
  // HOLD is a safety net: the output register is always empty while a multiply
  // runs, because nothing else can be accepted in that window.
  assign w_load_mul = (((r_state == MUL) && w_mul_done) || (r_state == HOLD)) && w_free;
  assign w_mul_nzcv = {w_product[MSB], (w_product == '0), 2'b00};

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_accept && w_is_mul),
    .a       (op_a),
    .b       (op_b),
    .done    (w_mul_done),
    .product (w_product)
  );
`else
  assign in_ready   = w_free;
  assign busy       = 1'b0;
  assign w_load_alu = w_accept;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_res_nzcv  <= '0;
      r_status    <= '0;
`ifdef ALU_PIPE_MUL_EN
      r_state     <= IDLE;
      r_mul_s     <= 1'b0;
`endif
    end else begin
      // A pop and a load on the same edge: the load below wins.
      if (r_out_valid && out_ready) r_out_valid <= 1'b0;

      if (w_load_alu) begin
        r_out_valid <= 1'b1;
        r_result    <= w_res;
        r_res_nzcv  <= w_nzcv;
        if (s_flag && w_defined) r_status <= w_nzcv;
      end

`ifdef ALU_PIPE_MUL_EN
      if (w_load_mul) begin
        r_out_valid <= 1'b1;
        r_result    <= w_product;
        r_res_nzcv  <= w_mul_nzcv;
        // Multiply only updates N and Z; C and V keep their old values.
        if (r_mul_s) begin
          r_status[NZCV_N] <= w_mul_nzcv[NZCV_N];
          r_status[NZCV_Z] <= w_mul_nzcv[NZCV_Z];
        end
      end

      case (r_state)
        IDLE: begin
          if (w_accept && w_is_mul) begin
            r_state <= MUL;
            r_mul_s <= s_flag;
          end
        end
        MUL: begin
          if (w_mul_done) r_state <= w_free ? IDLE : HOLD;
        end
        HOLD: begin
          if (w_free) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
`endif
    end
  end

  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign res_nzcv    = r_res_nzcv;
  assign status_nzcv = r_status;

endmodule : alu_pipe
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_alu_pipe                                                      |
// | Purpose : Self-checking bench for alu_pipe (WIDTH=32). Vector table,       |
// |           model-driven random ops with random backpressure, hand-written   |
// |           backpressure / multiply / reset sequences. Results are checked   |
// |           through an expected-value queue popped on each output handshake. |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_alu_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  command;
  logic        s_flag;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [3:0]  res_nzcv;
  logic [3:0]  status_nzcv;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [35:0] exp_q[$];
  logic [35:0] mon_e;

  typedef struct {
    logic [3:0]  cmd;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  nzcv;
    logic [3:0]  st;
  } vec_t;

  vec_t tbl[$];

  alu_pipe #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .command     (command),
    .s_flag      (s_flag),
    .op_a        (op_a),
    .op_b        (op_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .res_nzcv    (res_nzcv),
    .status_nzcv (status_nzcv),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Output monitor: every handshake pops one expected {result, nzcv}.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual=0x%0h required=none", result);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_result", result, mon_e[35:4]);
        check("out_nzcv", {28'd0, res_nzcv}, {28'd0, mon_e[3:0]});
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 just after the accept edge.
  task automatic issue(input logic [3:0] cmd, input logic s, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic [3:0] en,
                       input logic [3:0] est);
    int n;
    logic ok;
    in_valid = 1'b1;
    command  = cmd;
    s_flag   = s;
    op_a     = a;
    op_b     = b;
    n        = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    ok = in_ready;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout actual=in_ready_0 required=in_ready_1 cmd=%b", cmd);
    end else begin
      exp_q.push_back({er, en});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (ok) check("status_nzcv", {28'd0, status_nzcv}, {28'd0, est});
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_result"}, result, 32'd0);
    check({tag, "_res_nzcv"}, {28'd0, res_nzcv}, 32'd0);
    check({tag, "_status"}, {28'd0, status_nzcv}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  function automatic logic is_def(input logic [3:0] cmd);
    return (cmd >= 4'd1) && (cmd <= 4'd9);
  endfunction

  // Reference model using 64-bit arithmetic and signed-range overflow tests.
  function automatic logic [35:0] model(input logic [3:0] cmd, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin);
    longint unsigned ua, ub, k, t;
    longint sa, sb, sr;
    logic [31:0] r;
    logic c, v;
    ua = {32'd0, a};
    ub = {32'd0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = 32'd0; c = 1'b0; v = 1'b0; k = 0; t = 0; sr = 0;
    case (cmd)
      4'b0001: r = b;
      4'b1001: r = ~b;
      4'b0010, 4'b0011: begin
        k  = (cmd == 4'b0011) ? {63'd0, cin} : 64'd0;
        t  = ua + ub + k;
        r  = t[31:0];
        c  = t[32];
        sr = sa + sb + $signed(k);
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'b0100, 4'b0101: begin
        k  = (cmd == 4'b0101) ? {63'd0, !cin} : 64'd0;
        r  = a - b - k[31:0];
        c  = (ua < ub + k);
        sr = sa - sb - $signed(k);
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'b0110: r = a & b;
      4'b0111: r = a | b;
      4'b1000: r = a ^ b;
      default: r = 32'd0;
    endcase
    return {r, r[31], (r == 32'd0), c, v};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  logic [3:0]  m_status;
  logic [3:0]  r_cmd;
  logic        r_s;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [35:0] r_m;
  logic        rand_phase;
  int          nbusy;
  int          bad_rdy;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; command = 4'd0; s_flag = 1'b0;
    op_a = 32'd0; op_b = 32'd0; out_ready = 1'b1; rand_phase = 1'b0;

    // Vector table: status column is the running status after each accept.
    tbl.push_back('{4'b0010, 1'b1, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b1001, 4'b1001});
    tbl.push_back('{4'b0010, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110, 4'b0110});
    tbl.push_back('{4'b0011, 1'b0, 32'h00000000, 32'h00000000, 32'h00000001, 4'b0000, 4'b0110});
    tbl.push_back('{4'b0100, 1'b1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 4'b1010, 4'b1010});
    tbl.push_back('{4'b1100, 1'b1, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 4'b0100, 4'b1010});
    tbl.push_back('{4'b0101, 1'b1, 32'h0000000A, 32'h00000003, 32'h00000007, 4'b0000, 4'b0000});
    tbl.push_back('{4'b0101, 1'b1, 32'h0000000A, 32'h00000003, 32'h00000006, 4'b0000, 4'b0000});
    tbl.push_back('{4'b0001, 1'b1, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 4'b0100, 4'b0100});
    tbl.push_back('{4'b1001, 1'b1, 32'hDEADBEEF, 32'h00000000, 32'hFFFFFFFF, 4'b1000, 4'b1000});
    tbl.push_back('{4'b1000, 1'b0, 32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 4'b0000, 4'b1000});
    tbl.push_back('{4'b0111, 1'b1, 32'h00000F00, 32'h000000F0, 32'h00000FF0, 4'b0000, 4'b0000});
    tbl.push_back('{4'b0000, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b0100, 4'b0000});
`ifndef ALU_PIPE_MUL_EN
    tbl.push_back('{4'b1010, 1'b1, 32'h00000003, 32'h00000005, 32'h00000000, 4'b0100, 4'b0000});
`endif
    tbl.push_back('{4'b0100, 1'b1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0001, 4'b0001});
    tbl.push_back('{4'b0011, 1'b1, 32'h00000001, 32'h00000001, 32'h00000002, 4'b0000, 4'b0000});

    #12;
    check_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back table ops at full throughput.
    for (int i = 0; i < tbl.size(); i++)
      issue(tbl[i].cmd, tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].nzcv, tbl[i].st);
    m_status = tbl[tbl.size() - 1].st;
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: held result, stalled second op, then same-edge pop+push.
    out_ready = 1'b0;
    issue(4'b0110, 1'b0, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 4'b0000, m_status);
    fork
      issue(4'b0111, 1'b0, 32'h00000001, 32'h00000002, 32'h00000003, 4'b0000, m_status);
      begin
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready", {31'd0, in_ready}, 32'd0);
          check("bp_out_valid", {31'd0, out_valid}, 32'd1);
          check("bp_result", result, 32'h0000F000);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;

    // Random ops against the model with random output backpressure.
    rand_phase = 1'b1;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          r_cmd = 4'($urandom_range(0, 15));
          if (r_cmd == 4'b1010) r_cmd = 4'b1011;
          r_s = 1'($urandom_range(0, 1));
          r_a = pick();
          r_b = pick();
          r_m = model(r_cmd, r_a, r_b, m_status[1]);
          if (r_s && is_def(r_cmd)) m_status = r_m[3:0];
          issue(r_cmd, r_s, r_a, r_b, r_m[35:4], r_m[3:0], m_status);
        end
        rand_phase = 1'b0;
      end
      begin
        while (rand_phase) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

`ifdef ALU_PIPE_MUL_EN
    // Set C so that a multiply can be seen to preserve it.
    issue(4'b0010, 1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b0110, 4'b0110);
    issue(4'b1010, 1'b1, 32'h00010000, 32'h00010001, 32'h00010000, 4'b0000, 4'b0110);
    nbusy = 0; bad_rdy = 0;
    @(negedge clk);
    while (busy && nbusy < 100) begin
      if (in_ready || out_valid) bad_rdy++;
      nbusy++;
      @(negedge clk);
    end
    check("mul_busy_cycles", nbusy, 32'd32);
    check("mul_ready_low", bad_rdy, 32'd0);
    check("mul_out_valid", {31'd0, out_valid}, 32'd1);
    check("mul_status", {28'd0, status_nzcv}, 32'b0010);
    @(posedge clk);
    #1;

    // Multiply while the consumer is stalled: product lands and is held.
    out_ready = 1'b0;
    issue(4'b1010, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'b0000, 4'b0010);
    nbusy = 0;
    @(negedge clk);
    while (busy && nbusy < 100) begin
      nbusy++;
      @(negedge clk);
    end
    check("mul2_busy_cycles", nbusy, 32'd32);
    repeat (3) begin
      check("mul2_out_valid", {31'd0, out_valid}, 32'd1);
      check("mul2_result", result, 32'h00000001);
      check("mul2_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset after step E10 of a multiply.
    issue(4'b1010, 1'b1, 32'h00000007, 32'h00000009, 32'h0000003F, 4'b0000, 4'b0010);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_reset("midmul_reset");
`else
    // Reset while a result is held under backpressure.
    out_ready = 1'b0;
    issue(4'b0110, 1'b1, 32'h000000FF, 32'h0000000F, 32'h0000000F, 4'b0000, 4'b0000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check_reset("held_reset");
    out_ready = 1'b1;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Carry was cleared by reset, so ADC adds nothing extra.
    issue(4'b0011, 1'b1, 32'h00000002, 32'h00000003, 32'h00000005, 4'b0000, 4'b0000);
    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_alu_pipe
`default_nettype wire
